// File: rtl/master_control.sv
// Master side of the chip-to-chip link: 4-phase request/ack handshake,
// notice delay before data launch, ack synchroniser and timeout abort.
module master_control #(
  parameter int unsigned DELAY_CYCLES   = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 300_000_000,
  parameter int unsigned CNT_W          = 29
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [2:0] sw_data,
  input  logic       ack,
  output logic       request,
  output logic       valid,
  output logic [2:0] data_out,
  output logic       notice,
  output logic       busy,
  output logic       error
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DELAY,
    DATA
  } state_t;

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       tx_q, tx_d;
  logic [2:0]       data_q, data_d;
  logic             ack_m_q, ack_s_q;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic             notice_q, notice_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;

  logic dly_done, to_done;

  assign dly_done = (cnt_q == DLY_LAST);
  assign to_done  = (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (send) state_d = REQ;
      REQ: begin
        if (ack_s_q)      state_d = DELAY;
        else if (to_done) state_d = IDLE;
      end
      DELAY: if (dly_done) state_d = DATA;
      DATA: begin
        if (!ack_s_q)     state_d = IDLE;
        else if (to_done) state_d = IDLE;
      end
    endcase
  end

  // ack_s takes priority over the timeout terminal count
  always_comb begin
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    data_d   = data_q;
    req_d    = req_q;
    valid_d  = valid_q;
    notice_d = notice_q;
    busy_d   = busy_q;
    error_d  = error_q;
    unique case (state_q)
      IDLE: begin
        if (send) begin
          tx_d    = sw_data;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          error_d = 1'b0;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (ack_s_q) begin
          req_d    = 1'b0;
          notice_d = 1'b1;
          cnt_d    = '0;
        end else if (to_done) begin
          req_d   = 1'b0;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DELAY: begin
        if (dly_done) begin
          notice_d = 1'b0;
          valid_d  = 1'b1;
          data_d   = tx_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (!ack_s_q) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (to_done) begin
          valid_d = 1'b0;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_m_q  <= 1'b0;
      ack_s_q  <= 1'b0;
      cnt_q    <= '0;
      tx_q     <= 3'b000;
      data_q   <= 3'b000;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      notice_q <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      ack_m_q  <= ack;
      ack_s_q  <= ack_m_q;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      data_q   <= data_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      notice_q <= notice_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
    end
  end

  assign request  = req_q;
  assign valid    = valid_q;
  assign data_out = data_q;
  assign notice   = notice_q;
  assign busy     = busy_q;
  assign error    = error_q;

endmodule

// File: doc/master_control.md
Name: master_control

Overview:
- Master-side control FSM for the chip-to-chip link; drives the slave's request/valid/data inputs and consumes its ack.
- Sits between a one-pulsed "send" button plus a 3-bit switch bank and the inter-board wires.
- Runs a 4-phase handshake:
  - raise request;
  - wait for ack, then drop request;
  - wait one notice period;
  - present data with valid until ack falls.
- Adds ack synchronisation, a timeout/error path and a busy indication.

Parameters:
- DELAY_CYCLES, default 100_000_000: cycles notice stays high between ack receipt and data launch (1 s at 100 MHz).
- TIMEOUT_CYCLES, default 300_000_000: maximum cycles spent waiting on any ack edge before aborting.
- CNT_W, default 29: counter width; must hold max(DELAY_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, synchronous, active-low.
- send, input, 1: single-cycle send pulse from the debounce/one-pulse stage.
- sw_data, input, 3: value to transmit; sampled on an accepted send.
- ack, input, 1: asynchronous ack from slave board.
- request, output, 1: request to slave.
- valid, output, 1: data-valid strobe to slave.
- data_out, output, 3: data bus to slave.
- notice, output, 1: LED; high for DELAY_CYCLES after ack received.
- busy, output, 1: high whenever state != IDLE.
- error, output, 1: sticky timeout flag.

Behaviour:
- Reset (rst_n == 0 at a clk edge):
  - request, valid, notice, busy, error = 0; data_out = 3'b000.
  - Counter = 0; both ack sync flops = 0; state = IDLE.
  - Reset mid-handshake aborts immediately with these same values.
- All outputs are registered. ack passes through a 2-flop synchroniser; the FSM uses only ack_s, the second flop.
- States: IDLE, REQ, DELAY, DATA.
- IDLE:
  - On send == 1: capture sw_data into tx_reg, request <= 1, busy <= 1, error <= 0, counter <= 0, go to REQ.
  - request rises the cycle after the send pulse.
  - Without send, stay in IDLE with all outputs held (error keeps its value).
- REQ (waiting for ack_s high):
  - If ack_s == 1: request <= 0, notice <= 1, counter <= 0, go to DELAY.
  - Else if counter == TIMEOUT_CYCLES-1: request <= 0, error <= 1, busy <= 0, go to IDLE.
  - Else counter += 1.
- DELAY:
  - notice stays high.
  - When counter == DELAY_CYCLES-1: notice <= 0, valid <= 1, data_out <= tx_reg, counter <= 0, go to DATA.
  - Else counter += 1.
  - notice is therefore high for exactly DELAY_CYCLES cycles.
  - ack is ignored in DELAY.
- DATA (waiting for ack_s low):
  - data_out and valid are held stable.
  - If ack_s == 0: valid <= 0, busy <= 0, go to IDLE. data_out keeps its last value until the next launch.
  - Else if counter == TIMEOUT_CYCLES-1: valid <= 0, error <= 1, busy <= 0, go to IDLE.
  - Else counter += 1.
- send pulses arriving in any non-IDLE state are dropped; they are not queued.
- When ack_s arrives in the same cycle as the timeout terminal count, ack wins (handshake proceeds, no error).
- sw_data changes after capture have no effect on the value in flight.
- Counter compares use CNT_W-bit unsigned equality. The counter never wraps because it is cleared on every state entry.

Test Plan (sim overrides: DELAY_CYCLES = 4, TIMEOUT_CYCLES = 20):
1. Reset held 3 cycles with send = 1 and ack = 1
   -> all outputs 0, state IDLE; no request after release until a fresh send pulse.
2. sw_data = 3'b101 with a send pulse; slave model raises ack 5 cycles later
   -> request high the next cycle; request drops 3 cycles after ack rises (2 sync + 1 register); notice high exactly 4 cycles; then valid = 1 with data_out = 101.
3. Continuing from 2: slave drops ack 6 cycles after valid rises
   -> valid falls 3 cycles later, busy = 0, data_out stays 101, error = 0.
4. Send pulse with ack held low
   -> request is high exactly 20 cycles, then drops; error = 1, busy = 0. A later successful send clears error on acceptance.
5. Extra send pulses (sw_data = 010) during REQ and DELAY of a transfer of 011
   -> data_out = 011; only one request pulse is issued.
6. rst_n asserted while in DATA with valid = 1
   -> valid = 0, data_out = 000, busy = 0 on the next edge; a following send starts a clean handshake.
7. Integrate with the slave model, 3 back-to-back transfers (1, 6, 7)
   -> the slave's data output shows 1, 6, 7 in order; no spurious re-request.
